onehot_encoder_arb: RTL
=======================

// Module: onehot_encoder_arb
// PURPOSE
//  Reverse path of the control-unit opcode decoder. Collects up to N_REQ one-hot request lines
//  and re-encodes them to a binary index. Example use: unit done/interrupt strobes encoded back
//  into a 4-bit opcode-space index. Requests are latched, arbitrated round-robin and presented
//  through a registered valid/ready output. One code per accepted request.
// PARAMETERS
//  N_REQ    12  number of request lines; legal range 2..2**CODE_W
//  CODE_W    4  width of encoded index output
//  CNT_W     8  width of saturating coalesce counter
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  req_in       in   N_REQ   request strobes; any number of bits may be set in one cycle
//  EN_IN        in   1       sample enable; req_in ignored when 0
//  code_out     out  CODE_W  encoded index of granted request (registered)
//  valid_out    out  1       code_out holds an unconsumed code
//  ready_in     in   1       consumer accepts code_out when valid_out&&ready_in at clk edge
//  pending_out  out  N_REQ   latched, not-yet-issued requests (registered)
//  coalesce_cnt out  CNT_W   count of requests merged into an already-pending bit; saturates
// BEHAVIOUR
//  Reset (async, rst_n=0): code_out=0, valid_out=0, pending_out=0, coalesce_cnt=0, ptr=N_REQ-1.
//   Reset mid-handshake discards the held code and all pending requests.
//  Request set: in = req_in & {N_REQ{EN_IN}}; cand = pending_out | in (combinational).
//  Output slot free: free = !valid_out || ready_in.
//  FSM: 2 states, encoded by valid_out.
//   EMPTY (valid_out=0): if cand!=0 -> load, go FULL; else stay.
//   FULL  (valid_out=1): if ready_in && cand!=0 -> load, stay FULL (back-to-back, no bubble);
//                        if ready_in && cand==0 -> valid_out<=0, go EMPTY;
//                        if !ready_in -> hold code_out stable; no load.
//  Load: grant g = first set bit of cand searching ptr+1, ptr+2, ... wrapping N_REQ-1 -> 0.
//   code_out<=g; valid_out<=1; ptr<=g; pending_out <= cand & ~(1<<g).
//  No load: pending_out <= cand.
//  Latency: request sampled at edge k with slot free -> code_out/valid_out valid after edge k.
//   Minimum latency is 1 clk.
//  Same-cycle set/clear: a bit granted at edge k and re-asserted on req_in in that cycle is
//   consumed by the grant. It is not re-pended; one strobe yields exactly one code.
//  Coalescing: for each bit with in[i]=1 and pending_out[i]=1 at the edge, coalesce_cnt
//   += 1 (popcount of in & pending_out). It saturates at 2**CNT_W-1 and never wraps.
//   The request is not duplicated.
//  Fairness: each pending bit is granted within N_REQ loads.
//  Width rule: g is zero-extended to CODE_W. Index values >= N_REQ are never produced.
//  EN_IN=0: no new pends; pending requests keep draining normally.
//  Consumer misuse: ready_in while valid_out=0 is ignored.
// TESTING
//  1 Reset: rst_n=0 asserted mid-cycle with pending -> all outputs 0 immediately, ptr=11.
//  2 Single: req_in=12'h020, EN_IN=1, ready_in=1 for 1 clk -> next edge code_out=5,
//    valid_out=1. Following edge valid_out=0.
//  3 Round-robin: req_in=12'hFFF for 1 clk, ready_in=1 -> codes 0,1,...,11 on consecutive
//    clks, no gaps. pending_out reaches 0 after the 12th code.
//  4 Backpressure: code 3 valid, ready_in=0 for 5 clks while req_in pulses bit 7 ->
//    code_out stays 3, pending_out=12'h080. Raise ready_in -> next code 7.
//  5 Coalesce: bit 2 pending, re-pulse bit 2 three times with ready_in=0 ->
//    coalesce_cnt=3, exactly one code 2 issued. Saturation: 300 merges -> coalesce_cnt=255.
//  6 Enable: EN_IN=0 with req_in=12'hFFF -> no pends, valid_out stays 0.

Source files
------------

// File: rtl/onehot_encoder_arb.sv
// onehot_encoder_arb: latches one-hot request strobes and issues their binary indices round-robin
// through a registered valid/ready slot, counting requests merged into already-pending bits.
module onehot_encoder_arb #(
  parameter int N_REQ  = 12,
  parameter int CODE_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req_in,
  input  logic              EN_IN,
  output logic [CODE_W-1:0] code_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [N_REQ-1:0]  pending_out,
  output logic [CNT_W-1:0]  coalesce_cnt
);
  localparam int SW = CNT_W + $clog2(N_REQ + 1);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [N_REQ-1:0] in_req, cand, pend_nxt, one;
  logic [CODE_W-1:0] ptr, grant, lo, hi;
  logic hi_found, free, load;
  logic [SW-1:0] cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;
  assign in_req = req_in & {N_REQ{EN_IN}};
  assign cand = pending_out | in_req;
  assign valid_out = state == FULL;
  assign free = !valid_out || ready_in;
  assign load = free && |cand;
  // Lowest set bit above ptr wins; otherwise wrap to the lowest set bit overall.
  always_comb begin
    lo = '0;
    hi = '0;
    hi_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) lo = CODE_W'(i);
      if (cand[i] && i > int'(ptr)) begin
        hi = CODE_W'(i);
        hi_found = 1'b1;
      end
    end
  end
  assign grant = hi_found ? hi : lo;
  always_comb state_nxt = load ? FULL : (free ? EMPTY : state);
  assign one = N_REQ'(1);
  assign pend_nxt = load ? cand & ~(one << grant) : cand;
  assign cnt_sum = SW'(coalesce_cnt) + SW'($countones(in_req & pending_out));
  assign cnt_nxt = cnt_sum > SW'({CNT_W{1'b1}}) ? '1 : cnt_sum[CNT_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      code_out <= '0;
      ptr <= CODE_W'(N_REQ - 1);
      pending_out <= '0;
      coalesce_cnt <= '0;
    end else begin
      state <= state_nxt;
      pending_out <= pend_nxt;
      coalesce_cnt <= cnt_nxt;
      if (load) begin
        code_out <= grant;
        ptr <= grant;
      end
    end
  end
endmodule
